// File: rtl/versat_cmul_pkg.sv
// rtl/versat_cmul_pkg.sv - shared types, latency constant and saturating shift helper
// Purpose: FSM state encoding, pipeline latency and the output shift/saturate
// function used by the complex multiply/accumulate unit.
package versat_cmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STREAM,
        DRAIN
    } state_t;

    // Pipeline stages after the input capture register.
    localparam int LAT = 3;

    // Arithmetic (floor) right shift followed by saturation to a signed h-bit
    // range. Callers sign-extend into 64 bits and truncate the result to h bits,
    // so every accumulator width up to 64 bits shares this one helper.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] value,
        input int                 sh,
        input int                 h
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = value >>> sh;
        hi = (64'sd1 <<< (h - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (h - 1));
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/versat_cmul_acc_if.sv
// rtl/versat_cmul_acc_if.sv - control, operand and result bundle of the complex MAC unit
// Purpose: groups run/done control, config, operand streams and the result.
// master drives run, config and operands; slave (the unit) drives done/out0/out_valid.
interface versat_cmul_acc_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 10,
    parameter int SH_W   = $clog2(DATA_W)
);
    logic              run;
    logic              done;
    logic [DATA_W-1:0] in0;
    logic [DATA_W-1:0] in1;
    logic [31:0]       delay0;
    logic [LEN_W-1:0]  length;
    logic              conj;
    logic              acc;
    logic [SH_W-1:0]   shift;
    logic [DATA_W-1:0] out0;
    logic              out_valid;

    modport master (
        output run, in0, in1, delay0, length, conj, acc, shift,
        input  done, out0, out_valid
    );

    modport slave (
        input  run, in0, in1, delay0, length, conj, acc, shift,
        output done, out0, out_valid
    );
endinterface

// File: rtl/versat_cmul_core.sv
// rtl/versat_cmul_core.sv - three-stage complex multiply / accumulate datapath
// Purpose: input capture, products, combine (optional conjugate) with
// accumulation, then shift/saturate to the packed output.
// Ports: clk, rst (async active-low); sample_en_i/last_i mark a captured
// sample and the final one; clr_i clears the accumulators; in0_i/in1_i
// operands; conj_i/acc_i/shift_i latched config; out0_o/out_valid_o result.
module versat_cmul_core
    import versat_cmul_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int GUARD_W = 4,
    parameter int SH_W    = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en_i,
    input  logic              last_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] in0_i,
    input  logic [DATA_W-1:0] in1_i,
    input  logic              conj_i,
    input  logic              acc_i,
    input  logic [SH_W-1:0]   shift_i,
    output logic [DATA_W-1:0] out0_o,
    output logic              out_valid_o
);
    localparam int H  = DATA_W / 2;
    localparam int PW = 2 * H;
    localparam int CW = PW + 1;
    // Accumulator width must stay within the 64-bit sat_shift argument.
    localparam int AW = CW + GUARD_W;

    logic [DATA_W-1:0]     a_q, b_q;
    logic                  v0_q, l0_q;
    logic signed [H-1:0]   ar, ai, br, bi;
    logic signed [PW-1:0]  rr_q, ii_q, ri_q, ir_q;
    logic                  v1_q, l1_q;
    logic signed [CW-1:0]  rr_e, ii_e, ri_e, ir_e, cr_d, ci_d;
    logic signed [CW-1:0]  pr_q, pi_q;
    logic                  v2_q, l2_q;
    logic signed [AW-1:0]  accr_q, acci_q;
    logic signed [63:0]    src_r, src_i;
    logic [H-1:0]          yr_d, yi_d;
    logic                  emit_d;
    logic [DATA_W-1:0]     out0_q;
    logic                  out_valid_q;

    assign ar = a_q[DATA_W-1:H];
    assign ai = a_q[H-1:0];
    assign br = b_q[DATA_W-1:H];
    assign bi = b_q[H-1:0];

    always_comb begin
        rr_e = CW'(rr_q);
        ii_e = CW'(ii_q);
        ri_e = CW'(ri_q);
        ir_e = CW'(ir_q);
        cr_d = conj_i ? (rr_e + ii_e) : (rr_e - ii_e);
        ci_d = conj_i ? (ir_e - ri_e) : (ri_e + ir_e);
    end

    // In accumulate mode only the stage-2 slot carrying the last sample emits;
    // out0 holds its previous value on every other cycle.
    always_comb begin
        src_r  = acc_i ? 64'(accr_q) : 64'(pr_q);
        src_i  = acc_i ? 64'(acci_q) : 64'(pi_q);
        yr_d   = H'(sat_shift(src_r, 32'(shift_i), H));
        yi_d   = H'(sat_shift(src_i, 32'(shift_i), H));
        emit_d = v2_q & (~acc_i | l2_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q         <= '0;
            b_q         <= '0;
            v0_q        <= 1'b0;
            l0_q        <= 1'b0;
            rr_q        <= '0;
            ii_q        <= '0;
            ri_q        <= '0;
            ir_q        <= '0;
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            pr_q        <= '0;
            pi_q        <= '0;
            v2_q        <= 1'b0;
            l2_q        <= 1'b0;
            accr_q      <= '0;
            acci_q      <= '0;
            out0_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            v0_q <= sample_en_i;
            l0_q <= sample_en_i & last_i;
            if (sample_en_i) begin
                a_q <= in0_i;
                b_q <= in1_i;
            end

            v1_q <= v0_q;
            l1_q <= l0_q;
            if (v0_q) begin
                rr_q <= PW'(ar) * PW'(br);
                ii_q <= PW'(ai) * PW'(bi);
                ri_q <= PW'(ar) * PW'(bi);
                ir_q <= PW'(ai) * PW'(br);
            end

            v2_q <= v1_q;
            l2_q <= l1_q;
            if (v1_q) begin
                pr_q <= cr_d;
                pi_q <= ci_d;
            end
            // clr_i only fires on the start edge, when the pipeline is empty.
            if (clr_i) begin
                accr_q <= '0;
                acci_q <= '0;
            end else if (v1_q && acc_i) begin
                accr_q <= accr_q + AW'(cr_d);
                acci_q <= acci_q + AW'(ci_d);
            end

            out_valid_q <= emit_d;
            if (emit_d) begin
                out0_q <= {yr_d, yi_d};
            end
        end
    end

    assign out0_o      = out0_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: rtl/versat_cmul_acc.sv
// rtl/versat_cmul_acc.sv - Versat complex multiplier / MAC functional unit (top)
// Purpose: run/done FSM, start delay and sample counters, config latch.
// Ports: clk, rst (async active-low); bus (slave) carries run/done, config
// (delay0, length, conj, acc, shift), operands in0/in1 and out0/out_valid.
module versat_cmul_acc
    import versat_cmul_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 10,
    parameter int GUARD_W = 4,
    parameter int SH_W    = $clog2(DATA_W)
) (
    input  logic          clk,
    input  logic          rst,
    versat_cmul_acc_if.slave bus
);
    state_t             state_q;
    logic               done_q;
    logic [31:0]        cnt_q;
    logic [LEN_W-1:0]   smp_q;
    logic [LEN_W-1:0]   len_q;
    logic               conj_q;
    logic               acc_q;
    logic [SH_W-1:0]    shift_q;

    logic               start;
    logic               sample_en;
    logic               last_smp;

    assign start     = (state_q == IDLE) && bus.run;
    assign sample_en = (state_q == STREAM) && (len_q != '0);
    assign last_smp  = (smp_q == len_q - LEN_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            smp_q   <= '0;
            len_q   <= '0;
            conj_q  <= 1'b0;
            acc_q   <= 1'b0;
            shift_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.run) begin
                        len_q   <= bus.length;
                        conj_q  <= bus.conj;
                        acc_q   <= bus.acc;
                        shift_q <= bus.shift;
                        cnt_q   <= bus.delay0;
                        smp_q   <= '0;
                        done_q  <= 1'b0;
                        state_q <= (bus.delay0 == 32'd0) ? STREAM : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 32'd1;
                    if (cnt_q == 32'd1) begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (len_q == '0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        smp_q <= smp_q + LEN_W'(1);
                        if (last_smp) begin
                            // Last sample still has to pass the input register
                            // and LAT stages; return to IDLE one cycle after the
                            // final result is presented.
                            cnt_q   <= 32'(LAT);
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_q == 32'd0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.done = done_q;

    versat_cmul_core #(
        .DATA_W  (DATA_W),
        .GUARD_W (GUARD_W),
        .SH_W    (SH_W)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .sample_en_i (sample_en),
        .last_i      (last_smp),
        .clr_i       (start),
        .in0_i       (bus.in0),
        .in1_i       (bus.in1),
        .conj_i      (conj_q),
        .acc_i       (acc_q),
        .shift_i     (shift_q),
        .out0_o      (bus.out0),
        .out_valid_o (bus.out_valid)
    );

endmodule

// File: tb/tb_versat_cmul_acc.sv
// tb/tb_versat_cmul_acc.sv - self-checking bench for versat_cmul_acc
module tb_versat_cmul_acc;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [31:0] exp_out;
    logic [31:0] sa [16];
    logic [31:0] sb [16];

    versat_cmul_acc_if #(.DATA_W(32), .LEN_W(10)) bus ();

    versat_cmul_acc #(
        .DATA_W  (32),
        .LEN_W   (10),
        .GUARD_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          cj;
        bit          ac;
        int          sh;
        int          len;
        logic [31:0] expv;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, want);
        end
    endtask

    function automatic longint sx16(input logic [15:0] v);
        return longint'(signed'(v));
    endfunction

    function automatic logic [15:0] sat16(input longint x, input int sh);
        longint s;
        s = x >>> sh;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    // Complex product of packed operands, optionally with conj(b).
    function automatic void cmodel(input logic [31:0] a, input logic [31:0] b, input bit cj,
                                   output longint pr, output longint pi);
        longint ar, ai, br, bi;
        ar = sx16(a[31:16]);
        ai = sx16(a[15:0]);
        br = sx16(b[31:16]);
        bi = sx16(b[15:0]);
        if (cj) begin
            pr = ar * br + ai * bi;
            pi = ai * br - ar * bi;
        end else begin
            pr = ar * br - ai * bi;
            pi = ar * bi + ai * br;
        end
    endfunction

    // Starts one operation using sa/sb as samples and checks done, out_valid and
    // out0 after every edge from E0 until done rises. Returns the last out0 seen
    // with out_valid high. rerun_n != 0 pulses run for the edge E0+rerun_n.
    task automatic run_op(input int d, input int L, input bit cj, input bit ac, input int sh,
                          input int rerun_n, output logic [31:0] got);
        longint pr [16];
        longint pi [16];
        longint sr, si;
        int     total;
        int     k;
        bit     want_v;
        sr  = 0;
        si  = 0;
        got = 32'hDEADBEEF;
        for (int i = 0; i < L; i++) begin
            cmodel(sa[i], sb[i], cj, pr[i], pi[i]);
            sr += pr[i];
            si += pi[i];
        end
        total = (L == 0) ? d + 1 : d + L + 4;

        bus.run    = 1'b1;
        bus.delay0 = 32'(d);
        bus.length = 10'(L);
        bus.conj   = cj;
        bus.acc    = ac;
        bus.shift  = 5'(sh);
        bus.in0    = $urandom;
        bus.in1    = $urandom;
        @(posedge clk);
        #1;
        bus.run    = 1'b0;
        bus.delay0 = $urandom;
        bus.length = 10'($urandom);
        bus.conj   = 1'($urandom);
        bus.acc    = 1'($urandom);
        bus.shift  = 5'($urandom);

        for (int n = 0; n <= total; n++) begin
            if (ac) want_v = (L > 0) && (n == d + L + 3);
            else    want_v = (n >= d + 4) && (n < d + 4 + L);
            if (want_v) begin
                if (ac) exp_out = {sat16(sr, sh), sat16(si, sh)};
                else    exp_out = {sat16(pr[n-d-4], sh), sat16(pi[n-d-4], sh)};
            end
            chk($sformatf("done@E0+%0d", n), 32'(bus.done), 32'(n >= total));
            chk($sformatf("out_valid@E0+%0d", n), 32'(bus.out_valid), 32'(want_v));
            chk($sformatf("out0@E0+%0d", n), bus.out0, exp_out);
            if (bus.out_valid) got = bus.out0;
            if (n < total) begin
                k = n - d;
                if (k >= 0 && k < L) begin
                    bus.in0 = sa[k];
                    bus.in1 = sb[k];
                end else begin
                    bus.in0 = $urandom;
                    bus.in1 = $urandom;
                end
                bus.run = (n + 1 == rerun_n);
                @(posedge clk);
                #1;
            end
        end
        bus.run = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        int d, L, sh;
        bit cj, ac;

        tbl[0] = '{32'h00030004, 32'h0005FFFE, 1'b0, 1'b0, 0,  1, 32'h0017000E};
        tbl[1] = '{32'h00030004, 32'h0005FFFE, 1'b1, 1'b0, 0,  1, 32'h0007001A};
        tbl[2] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 15, 1, 32'h7FFF0000};
        tbl[3] = '{32'h7FFF0000, 32'h7FFF0000, 1'b0, 1'b0, 15, 1, 32'h7FFE0000};
        tbl[4] = '{32'h7FFF0000, 32'h7FFF0000, 1'b0, 1'b0, 0,  1, 32'h7FFF0000};
        tbl[5] = '{32'h00010001, 32'h00010001, 1'b0, 1'b1, 0,  4, 32'h00000008};

        errors     = 0;
        checks     = 0;
        exp_out    = '0;
        rst        = 1'b0;
        bus.run    = 1'b0;
        bus.in0    = '0;
        bus.in1    = '0;
        bus.delay0 = '0;
        bus.length = '0;
        bus.conj   = 1'b0;
        bus.acc    = 1'b0;
        bus.shift  = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_done", 32'(bus.done), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out0", bus.out0, 32'd0);
        rst = 1'b1;

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < tbl[t].len; i++) begin
                sa[i] = tbl[t].a;
                sb[i] = tbl[t].b;
            end
            run_op(0, tbl[t].len, tbl[t].cj, tbl[t].ac, tbl[t].sh, 0, got);
            chk($sformatf("tbl%0d_result", t), got, tbl[t].expv);
        end

        // Delayed start with ramp operands and a stray run mid-stream.
        for (int i = 0; i < 3; i++) begin
            sa[i] = {16'(i + 1), 16'(3 * i - 2)};
            sb[i] = {16'(2 * i + 3), 16'(-(i + 1))};
        end
        run_op(5, 3, 1'b0, 1'b0, 0, 7, got);

        // Zero-length operation.
        run_op(2, 0, 1'b0, 1'b0, 0, 0, got);

        // Asynchronous reset in the middle of an accumulate stream.
        for (int i = 0; i < 6; i++) begin
            sa[i] = $urandom;
            sb[i] = $urandom;
        end
        bus.run    = 1'b1;
        bus.delay0 = 32'd0;
        bus.length = 10'd6;
        bus.conj   = 1'b0;
        bus.acc    = 1'b1;
        bus.shift  = 5'd0;
        @(posedge clk);
        #1;
        bus.run = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_out0", bus.out0, 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd1);
        exp_out = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sa[0] = tbl[0].a;
        sb[0] = tbl[0].b;
        run_op(0, 1, 1'b0, 1'b0, 0, 0, got);
        chk("post_reset_result", got, tbl[0].expv);

        // Random back-to-back operations against the model.
        for (int r = 0; r < 14; r++) begin
            d  = $urandom_range(0, 3);
            L  = $urandom_range(0, 7);
            cj = 1'($urandom);
            ac = 1'($urandom);
            sh = $urandom_range(0, 31);
            for (int i = 0; i < L; i++) begin
                if (r < 7) begin
                    sa[i] = $urandom;
                    sb[i] = $urandom;
                end else begin
                    sa[i] = {16'($urandom_range(0, 400) - 200), 16'($urandom_range(0, 400) - 200)};
                    sb[i] = {16'($urandom_range(0, 400) - 200), 16'($urandom_range(0, 400) - 200)};
                end
            end
            run_op(d, L, cj, ac, sh, 0, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
